// File: rtl/cam_dvp_tx.sv
// DVP camera-style frame generator: vsync/href timing plus four selectable RGB565 test patterns.
// Outputs are registered from the next-cycle timing state, so data, href, vsync and frame_done stay aligned.
module cam_dvp_tx #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_BLANK  = 144,
  parameter int          V_SYNC   = 3,
  parameter int          V_BACK   = 17,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FRONT  = 10,
  parameter logic [15:0] SOLID    = 16'h07FF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] pat_sel,
  output logic [7:0] cam_data,
  output logic       cam_href,
  output logic       cam_vsync,
  output logic       frame_done
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int BAR_W    = H_ACTIVE / 8;
  localparam int V_MAX_A  = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int V_MAX_B  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int BW       = $clog2(LINE_LEN);
  localparam int LW       = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t          state, nxt_state;
  logic [LW-1:0]   line_cnt, nxt_line;
  logic [BW-1:0]   byte_cnt, nxt_byte;
  logic [1:0]      pat;
  logic [15:0]     pix_cnt;
  logic [15:0]     pixel;
  logic [7:0]      nxt_data;
  logic            nxt_href;
  logic            line_end;
  logic            block_end;
  logic            frame_start;
  logic            nxt_done;
  int              x_pix;

  function automatic int lines_of(input state_t s);
    case (s)
      VSYNC:   return V_SYNC;
      VBACK:   return V_BACK;
      ACTIVE:  return V_ACTIVE;
      VFRONT:  return V_FRONT;
      default: return 1;
    endcase
  endfunction

  function automatic logic [15:0] bar_color(input logic [2:0] bar);
    case (bar)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      3'd5:    return 16'hF800;
      3'd6:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  // Next timing position; en only matters in IDLE and at the very end of VFRONT.
  always_comb begin
    nxt_state = state;
    nxt_line  = line_cnt;
    nxt_byte  = byte_cnt;
    line_end  = (int'(byte_cnt) == LINE_LEN - 1);
    block_end = line_end && (int'(line_cnt) == lines_of(state) - 1);
    if (state == IDLE) begin
      if (en) nxt_state = VSYNC;
    end else begin
      if (line_end) begin
        nxt_byte = '0;
        nxt_line = line_cnt + LW'(1);
      end else begin
        nxt_byte = byte_cnt + BW'(1);
      end
      if (block_end) begin
        nxt_line = '0;
        case (state)
          VSYNC:   nxt_state = VBACK;
          VBACK:   nxt_state = ACTIVE;
          ACTIVE:  nxt_state = VFRONT;
          VFRONT:  nxt_state = en ? VSYNC : IDLE;
          default: nxt_state = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    x_pix = int'(nxt_byte) >> 1;
    case (pat)
      2'd0:    pixel = SOLID;
      2'd1:    pixel = bar_color(3'(x_pix / BAR_W));
      2'd2:    pixel = {5'(x_pix >> 5), 6'(int'(nxt_line) >> 3), ~5'(x_pix >> 5)};
      default: pixel = pix_cnt;
    endcase
    nxt_href    = (nxt_state == ACTIVE) && (int'(nxt_byte) < 2 * H_ACTIVE);
    nxt_data    = !nxt_href ? 8'h00 : (nxt_byte[0] ? pixel[7:0] : pixel[15:8]);
    frame_start = (nxt_state == VSYNC) && (state != VSYNC);
    nxt_done    = (nxt_state == VFRONT) && (int'(nxt_line) == V_FRONT - 1) &&
                  (int'(nxt_byte) == LINE_LEN - 1);
  end

  // Pattern and pixel counter are frozen per frame; the counter steps after each second byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      line_cnt   <= '0;
      byte_cnt   <= '0;
      pat        <= 2'd0;
      pix_cnt    <= 16'h0000;
      cam_data   <= 8'h00;
      cam_href   <= 1'b0;
      cam_vsync  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state    <= nxt_state;
      line_cnt <= nxt_line;
      byte_cnt <= nxt_byte;
      if (frame_start) begin
        pat     <= pat_sel;
        pix_cnt <= 16'h0000;
      end else if (nxt_href && nxt_byte[0]) begin
        pix_cnt <= pix_cnt + 16'h0001;
      end
      cam_data   <= nxt_data;
      cam_href   <= nxt_href;
      cam_vsync  <= (nxt_state == VSYNC);
      frame_done <= nxt_done;
    end
  end

endmodule

// File: tb/tb_cam_dvp_tx.sv
// Directed bench for cam_dvp_tx with a 20-cycle line and 100-cycle frame.
module tb_cam_dvp_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] pat_sel;
  logic [7:0] cam_data;
  logic       cam_href;
  logic       cam_vsync;
  logic       frame_done;

  int tests_run    = 0;
  int tests_failed = 0;
  int frame_no     = 0;

  logic [7:0] bar_bytes [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                 8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

  cam_dvp_tx #(
    .H_ACTIVE(8), .H_BLANK(4), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(2), .V_FRONT(1),
    .SOLID(16'h07FF)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .pat_sel(pat_sel),
    .cam_data(cam_data), .cam_href(cam_href), .cam_vsync(cam_vsync), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic exp_href(input int c);
    return (c >= 40 && c < 56) || (c >= 60 && c < 76);
  endfunction

  // Hand-derived byte stream for each pattern with 8 pixels per line and y in {0,1}.
  function automatic logic [7:0] exp_data(input int c, input int pat);
    int line;
    int b;
    if (!exp_href(c)) return 8'h00;
    line = (c >= 60) ? 1 : 0;
    b    = c - ((line == 1) ? 60 : 40);
    case (pat)
      0:       return (b % 2 == 1) ? 8'hFF : 8'h07;
      1:       return bar_bytes[b];
      2:       return (b % 2 == 1) ? 8'h1F : 8'h00;
      default: return (b % 2 == 1) ? 8'(line * 8 + b / 2) : 8'h00;
    endcase
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, " data"},  16'(cam_data),   16'h0000);
    checkOutput({tag, " href"},  16'(cam_href),   16'h0000);
    checkOutput({tag, " vsync"}, 16'(cam_vsync),  16'h0000);
    checkOutput({tag, " done"},  16'(frame_done), 16'h0000);
  endtask

  // Called at a falling edge; the next rising edge starts frame cycle 0.
  task automatic applyStimulus(input int pat, input int chg_at, input int new_pat,
                               input int drop_at, input int reset_at);
    en = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checkOutput($sformatf("f%0d c%0d vsync", frame_no, c), 16'(cam_vsync), 16'(c < 20));
      checkOutput($sformatf("f%0d c%0d href", frame_no, c), 16'(cam_href), 16'(exp_href(c)));
      checkOutput($sformatf("f%0d c%0d done", frame_no, c), 16'(frame_done), 16'(c == 99));
      checkOutput($sformatf("f%0d c%0d data", frame_no, c), 16'(cam_data), 16'(exp_data(c, pat)));
      if (c == chg_at) pat_sel = 2'(new_pat);
      if (c == drop_at) en = 1'b0;
      if (c == reset_at) begin
        reset = 1'b1;
        break;
      end
    end
    frame_no++;
  endtask

  initial begin
    reset   = 1'b1;
    en      = 1'b0;
    pat_sel = 2'd0;
    repeat (3) @(negedge clk);
    checkIdle("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkIdle("idle");

    applyStimulus(0, 50, 1, -1, -1);
    applyStimulus(1, 50, 3, -1, -1);
    applyStimulus(3, -1, 0, -1, -1);
    applyStimulus(3, 50, 1, -1, -1);
    applyStimulus(1, 50, 2, -1, -1);
    applyStimulus(2, -1, 0, 30, -1);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkIdle($sformatf("after_en_drop %0d", i));
    end

    applyStimulus(2, -1, 0, -1, 45);
    @(negedge clk);
    checkIdle("mid_frame_reset");
    reset = 1'b0;
    applyStimulus(2, -1, 0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
